seq_datapath: RTL

//  Parametrised, self-sequencing successor of the 16-bit datapath. It holds a register file, A/B/C

---
 rtl/seq_dp_pkg.sv | 38 +++
 rtl/dp_regfile.sv | 27 ++
 rtl/seq_datapath.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seq_dp_pkg.sv
// Shared encodings for the self-sequencing datapath: op fields, write-back sources, FSM states.
package seq_dp_pkg;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RDA  = 3'd1,
        ST_RDB  = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    // Width-independent control fields latched when an operation is accepted.
    typedef struct packed {
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic       wb_en;
        logic       set_flags;
    } op_ctl_t;

endpackage

// File: rtl/dp_regfile.sv
// Register file: one synchronous write port, one combinational read port, async clear.
module dp_regfile #(
    parameter int W    = 16,
    parameter int NREG = 8,
    localparam int RW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [RW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [NREG-1:0][W-1:0] regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regs <= '0;
        else if (we)
            regs[waddr] <= wdata;
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/seq_datapath.sv
// Self-sequencing datapath: one start/done transaction walks an op through RDA, RDB, EXEC, WB.
module seq_datapath
    import seq_dp_pkg::*;
#(
    parameter int W    = 16,
    parameter int NREG = 8,
    parameter int PC_W = 9,
    localparam int RW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [RW-1:0]   rn,
    input  logic [RW-1:0]   rm,
    input  logic [RW-1:0]   rd,
    input  logic [1:0]      shift,
    input  logic [1:0]      alu_op,
    input  logic            asel,
    input  logic            bsel,
    input  logic [1:0]      vsel,
    input  logic            wb_en,
    input  logic            set_flags,
    input  logic [W-1:0]    sximm5,
    input  logic [W-1:0]    sximm8,
    input  logic [PC_W-1:0] pc,
    input  logic [W-1:0]    mdata,
    output logic            busy,
    output logic            done,
    output logic [W-1:0]    dp_out,
    output logic            N,
    output logic            V,
    output logic            Z
);

    state_t           state, state_nxt;
    op_ctl_t          ctl;
    logic [RW-1:0]    rn_q, rm_q, rd_q;
    logic [W-1:0]     imm5_q, imm8_q;
    logic [PC_W-1:0]  pc_q;
    logic [W-1:0]     a_q, b_q, c_q;
    logic             n_q, v_q, z_q, done_q;

    logic [RW-1:0]    raddr;
    logic [W-1:0]     rdata, b_sh, ain, bin, alu_out, wb_data;
    logic             ovf, rf_we;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_RDA;
            ST_RDA:  state_nxt = ST_RDB;
            ST_RDB:  state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Single read port is time-shared: rn during RDA, rm otherwise.
    assign raddr = (state == ST_RDA) ? rn_q : rm_q;

    always_comb begin
        b_sh = b_q;
        unique case (ctl.shift)
            SH_LSL:  b_sh = {b_q[W-2:0], 1'b0};
            SH_LSR:  b_sh = {1'b0, b_q[W-1:1]};
            SH_ASR:  b_sh = {b_q[W-1], b_q[W-1:1]};
            default: b_sh = b_q;
        endcase
    end

    assign ain = ctl.asel ? '0 : a_q;
    assign bin = ctl.bsel ? imm5_q : b_sh;

    always_comb begin
        alu_out = '0;
        ovf     = 1'b0;
        unique case (ctl.alu_op)
            ALU_ADD: begin
                alu_out = ain + bin;
                ovf     = (ain[W-1] == bin[W-1]) && (alu_out[W-1] != ain[W-1]);
            end
            ALU_SUB: begin
                alu_out = ain - bin;
                ovf     = (ain[W-1] != bin[W-1]) && (alu_out[W-1] != ain[W-1]);
            end
            ALU_AND:  alu_out = ain & bin;
            default:  alu_out = ~bin;
        endcase
    end

    always_comb begin
        wb_data = c_q;
        unique case (ctl.vsel)
            VSEL_PC:    wb_data = W'(pc_q);
            VSEL_IMM8:  wb_data = imm8_q;
            VSEL_MDATA: wb_data = mdata;
            default:    wb_data = c_q;
        endcase
    end

    assign rf_we = (state == ST_WB) && ctl.wb_en;

    dp_regfile #(.W(W), .NREG(NREG)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rf_we),
        .waddr (rd_q),
        .wdata (wb_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ctl    <= '0;
            rn_q   <= '0;
            rm_q   <= '0;
            rd_q   <= '0;
            imm5_q <= '0;
            imm8_q <= '0;
            pc_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            n_q    <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == ST_WB);
            unique case (state)
                ST_IDLE: if (start) begin
                    ctl    <= '{shift: shift, alu_op: alu_op, asel: asel, bsel: bsel,
                                vsel: vsel, wb_en: wb_en, set_flags: set_flags};
                    rn_q   <= rn;
                    rm_q   <= rm;
                    rd_q   <= rd;
                    imm5_q <= sximm5;
                    imm8_q <= sximm8;
                    pc_q   <= pc;
                end
                ST_RDA:  a_q <= rdata;
                ST_RDB:  b_q <= rdata;
                ST_EXEC: begin
                    c_q <= alu_out;
                    if (ctl.set_flags) begin
                        n_q <= alu_out[W-1];
                        z_q <= (alu_out == '0);
                        v_q <= ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != ST_IDLE);
    assign done   = done_q;
    assign dp_out = c_q;
    assign N      = n_q;
    assign V      = v_q;
    assign Z      = z_q;

endmodule
